// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the 4-requester register-file write arbiter.
package regfile_write_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int AW   = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter4.sv
// Combinational round-robin pick: first requester at or after ptr (mod 4) wins.
module rr_arbiter4
  import regfile_write_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      winner,
  output logic            valid
);

  logic [1:0] idx;

  // Scan farthest offset first so the nearest requester overwrites the result.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// 8-entry register file with a two-cycle round-robin write arbiter for 4 requesters.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N     = 32,
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*N-1:0] wr_data,
  output logic [NREQ-1:0]   gnt,
  input  logic [AW-1:0]     rd_addr,
  output logic [N-1:0]      rd_data,
  output logic              busy
);

  logic [0:0]      state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      win_q, win_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [N-1:0]    data_q, data_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [N-1:0]    regs_q [NREGS];
  logic            we;
  logic [1:0]      rr_win;
  logic            rr_valid;

  rr_arbiter4 u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (rr_win),
    .valid  (rr_valid)
  );

  // gnt is registered alongside the COMMIT transition so it is high exactly in COMMIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_d   = '0;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d = ST_COMMIT;
          win_d   = rr_win;
          addr_d  = wr_addr[AW*int'(rr_win) +: AW];
          data_d  = wr_data[N*int'(rr_win) +: N];
          gnt_d   = onehot4(rr_win);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = win_q + 2'd1;
        we      = (addr_q != '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
    end
  end

  // Address 0 is never written, so entry 0 holds its reset value forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (we) begin
      regs_q[addr_q] <= data_q;
    end
  end

  assign rd_data = (rd_addr == '0) ? '0 : regs_q[rd_addr];
  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: driver pushes expected grants/reads, monitor checks.
module tb_regfile_write_arbiter;
  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [11:0]   wr_addr;
  logic [4*N-1:0] wr_data;
  logic [3:0]    gnt;
  logic [2:0]    rd_addr;
  logic [N-1:0]  rd_data;
  logic          busy;

  logic [3:0]  exp_q[$];
  logic [34:0] rd_q[$];

  int  n_chk;
  int  n_fail;
  int  cyc;
  int  last_gnt_cyc;
  bit  have_prev;
  bit  prev_busy;
  bit  spacing_chk;
  bit  done;

  regfile_write_arbiter #(.N(N), .NREGS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    last_gnt_cyc = 0; have_prev = 1'b0; prev_busy = 1'b0;
  end

  always @(negedge clk) begin
    logic [3:0]  eg;
    logic [34:0] er;
    cyc++;
    if (!spacing_chk) have_prev = 1'b0;
    if (!rst_n) begin
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_gnt", 32'(gnt), 32'd0);
    end else begin
      chk("gnt_iff_busy", 32'(gnt != 4'd0), 32'(busy));
      if (busy) chk("busy_single_cycle", 32'(prev_busy), 32'd0);
      if (gnt != 4'd0) begin
        chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          eg = exp_q.pop_front();
          chk("gnt_order", 32'(gnt), 32'(eg));
        end
        if (spacing_chk && have_prev) chk("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd2);
        last_gnt_cyc = cyc;
        have_prev = 1'b1;
      end
    end
    prev_busy = busy;
    if (rd_q.size() > 0) begin
      er = rd_q.pop_front();
      chk($sformatf("rd_data[%0d]", er[34:32]), rd_data, er[31:0]);
    end
    if (done || cyc > 5000) begin
      if (!done) begin
        n_fail++;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      end
      chk("gnt_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_slot(input int k, input logic [2:0] a, input logic [31:0] d);
    wr_addr[3*k +: 3] = a;
    wr_data[N*k +: N] = d;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    rd_addr = a;
    rd_q.push_back({a, d});
  endtask

  // Requesters drop req once their grant is seen; optional scrambling of inputs.
  task automatic run_until_idle(input bit scramble);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      req = req & ~gnt;
      if (scramble) begin
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        wr_addr = 12'($urandom_range(0, 4095));
      end
      if (req == 4'd0 && !busy) break;
    end
  endtask

  task automatic issue(input logic [3:0] r);
    @(negedge clk); #1;
    req = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    spacing_chk = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset contents
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'd0);

    // Full contention from ptr=0: grants 0,1,2,3 two cycles apart
    set_slot(0, 3'd1, 32'h1111_0001);
    set_slot(1, 3'd2, 32'h2222_0002);
    set_slot(2, 3'd4, 32'h4444_0004);
    set_slot(3, 3'd6, 32'h6666_0006);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    spacing_chk = 1'b1;
    issue(4'b1111);
    run_until_idle(1'b0);
    spacing_chk = 1'b0;
    do_read(3'd1, 32'h1111_0001);
    do_read(3'd2, 32'h2222_0002);
    do_read(3'd4, 32'h4444_0004);
    do_read(3'd6, 32'h6666_0006);

    // Single write by requester 1; old value during COMMIT, inputs scrambled in COMMIT
    set_slot(1, 3'd5, 32'hDEAD_BEEF);
    exp_q.push_back(4'b0010);
    @(negedge clk); #1;
    req = 4'b0010;
    rd_addr = 3'd5;
    rd_q.push_back({3'd5, 32'd0});
    run_until_idle(1'b1);
    do_read(3'd5, 32'hDEAD_BEEF);

    // Requester 2 moves ptr to 3, then 0101 -> requester 0 first, then 2
    set_slot(2, 3'd3, 32'h3333_3333);
    exp_q.push_back(4'b0100);
    issue(4'b0100);
    run_until_idle(1'b0);
    set_slot(0, 3'd2, 32'hC0C0_C0C0);
    set_slot(2, 3'd4, 32'h4444_4444);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
    issue(4'b0101);
    run_until_idle(1'b0);
    do_read(3'd3, 32'h3333_3333);
    do_read(3'd2, 32'hC0C0_C0C0);
    do_read(3'd4, 32'h4444_4444);

    // Write to address 0 is granted and discarded
    set_slot(3, 3'd0, 32'h1234_5678);
    exp_q.push_back(4'b1000);
    issue(4'b1000);
    run_until_idle(1'b0);
    do_read(3'd0, 32'd0);

    // Reset during COMMIT abandons the write; requester 0 wins afterwards
    set_slot(2, 3'd3, 32'hA5A5_A5A5);
    issue(4'b0100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = 4'b0001;
    set_slot(0, 3'd7, 32'h0BAD_F00D);
    rd_addr = 3'd3;
    rd_q.push_back({3'd3, 32'd0});
    @(negedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    rd_q.push_back({3'd3, 32'd0});
    run_until_idle(1'b0);
    do_read(3'd7, 32'h0BAD_F00D);
    do_read(3'd3, 32'd0);
    do_read(3'd5, 32'd0);

    repeat (2) @(negedge clk);
    #1 done = 1'b1;
  end

endmodule
